demux_1to2_stream_buf: RTL and testbench
========================================

// Module: demux_1to2_stream_buf
// PURPOSE
//   Buffered 1-to-2 stream demultiplexer. Each valid/ready word is steered to one of two output
//   channels by sel_in, using the team's existing demux mapping: sel_in=1 -> channel 0,
//   sel_in=0 -> channel 1.
//   Each channel has its own DEPTH-entry FIFO, so a stalled consumer never blocks the other channel.
//   Sits between the upstream producer and two independent downstream consumers.
// PARAMETERS
//   DATA_W  8  width of the data word
//   DEPTH   4  entries per channel FIFO; must be a power of 2 and >= 2
// PORTS
//   clk_in        in   1       single clock; all state updates on the rising edge
//   rst_n_in      in   1       asynchronous reset, active-low
//   d_in          in   DATA_W  input data word
//   sel_in        in   1       route select: 1 -> ch0, 0 -> ch1
//   valid_in      in   1       upstream word valid
//   ready_out     out  1       block can accept the word, for the channel selected by sel_in
//   y0_data_out   out  DATA_W  ch0 head-of-FIFO data
//   y0_valid_out  out  1       ch0 FIFO not empty
//   y0_ready_in   in   1       ch0 consumer ready
//   y1_data_out   out  DATA_W  ch1 head-of-FIFO data
//   y1_valid_out  out  1       ch1 FIFO not empty
//   y1_ready_in   in   1       ch1 consumer ready
// BEHAVIOUR
//   - Reset (async assert, sync release): both FIFOs empty, pointers 0, counts 0, any in-flight data discarded.
//     While reset is asserted: ready_out=0, y0/y1_valid_out=0, y0/y1_data_out=0.
//     Reset mid-transfer behaves identically.
//   - ready_out = sel_in ? !full0 : !full1.
//     It depends on sel_in and registered full flags only; never on valid_in or any yN_ready_in.
//   - Input accept: valid_in & ready_out. The word is written into the selected FIFO at that rising edge.
//     Upstream must hold d_in and sel_in stable while valid_in=1 and ready_out=0; this is not checked.
//   - Output pop: yN_valid_out & yN_ready_in. Pops the head entry at the edge.
//     yN_data_out is the head entry, read from registers; undefined content when yN_valid_out=0.
//   - Latency: a word accepted at edge t appears on yN_valid_out/yN_data_out after edge t (next cycle).
//     There is no same-cycle input-to-output bypass.
//   - Per FIFO: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
//     count is $clog2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
//   - Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
//     This is legal when empty only as push-then-visible-next-cycle; the pop side needs valid=1, so no pop occurs.
//   - Full channel with a pop in the same cycle: ready_out stays 0 that cycle (no ready pass-through).
//     A push is accepted next cycle.
//   - Channel independence: full0 never deasserts ready_out when sel_in=0, and vice versa.
//   - Order is preserved within a channel. There is no ordering relation between channels.
//   - Data is never dropped or duplicated. An illegal push or pop is impossible by construction.
// CONFIGURATION
//   DEMUX_STATS_EN defined: adds the following ports:
//     stats_clr_in  in   1   synchronous clear of both counters
//     y0_cnt_out    out  16  ch0 delivered-word count
//     y1_cnt_out    out  16  ch1 delivered-word count
//   Counter rules:
//     - Increment on the channel's output pop; saturate at 16'hFFFF.
//     - Reset value 0.
//     - stats_clr_in has priority over increment in the same cycle.
//   DEMUX_STATS_EN undefined: these ports and counters do not exist. Datapath behaviour is identical.
// TESTING (DATA_W=8, DEPTH=4)
//   1. Routing/latency:
//      Stimulus: push 8'hA5 sel=1, then 8'h3C sel=0; both yN_ready_in=1.
//      Required: y0 shows A5 and y1 shows 3C, each one cycle after its accept, each valid for exactly one cycle.
//   2. Full/backpressure:
//      Stimulus: y0_ready_in=0; push 8'h01..8'h05 with sel=1.
//      Required: 01..04 accepted; ready_out=0 for 05 while sel=1, but ready_out=1 when sel is switched to 0.
//   3. Full+pop:
//      Stimulus: from the state of test 2, raise y0_ready_in.
//      Required: ready_out stays 0 in the pop cycle and is 1 next cycle.
//      Required: ch0 drains 01,02,03,04,05 in order.
//   4. Wrap-around:
//      Stimulus: 10 back-to-back words 8'h10..8'h19 sel=0 with y1_ready_in=1 throughout.
//      Required: all 10 emerge in order; count never exceeds 1.
//   5. Reset mid-op:
//      Stimulus: ch0 holds 3 words, ch1 holds 2 words; pulse rst_n_in low for 2 ns between clock edges.
//      Required: valids drop immediately; after release, no old data appears and ready_out=1.
//   6. Stats (DEMUX_STATS_EN):
//      Required: 3 ch0 pops -> y0_cnt_out=3.
//      Required: preload to 16'hFFFF (force), then pop -> count stays FFFF.
//      Required: clr together with a pop -> count 0.

Source files
------------

// File: rtl/demux_1to2_stream_buf.sv
// Buffered 1-to-2 stream demux: sel_in=1 -> ch0, sel_in=0 -> ch1, each channel behind its own FIFO.
// Optional macro DEMUX_STATS_EN adds per-channel saturating delivered-word counters.
`timescale 1ns/1ps
module demux_1to2_stream_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              sel_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] y0_data_out,
  output logic              y0_valid_out,
  input  logic              y0_ready_in,
  output logic [DATA_W-1:0] y1_data_out,
  output logic              y1_valid_out,
  input  logic              y1_ready_in
`ifdef DEMUX_STATS_EN
  ,
  input  logic              stats_clr_in,
  output logic [15:0]       y0_cnt_out,
  output logic [15:0]       y1_cnt_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]             full;
  logic [1:0]             valid;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             chan_sel;
  logic [1:0]             cons_ready;
  logic [1:0][DATA_W-1:0] head;
`ifdef DEMUX_STATS_EN
  logic [1:0][15:0]       stat_cnt;
`endif

  // Gated by reset so the producer sees no room while the block is held in reset.
  assign ready_out  = rst_n_in & (sel_in ? ~full[0] : ~full[1]);
  assign chan_sel   = {~sel_in, sel_in};
  assign cons_ready = {y1_ready_in, y0_ready_in};

  assign y0_data_out  = head[0];
  assign y0_valid_out = valid[0];
  assign y1_data_out  = head[1];
  assign y1_valid_out = valid[1];
`ifdef DEMUX_STATS_EN
  assign y0_cnt_out = stat_cnt[0];
  assign y1_cnt_out = stat_cnt[1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [DATA_W-1:0] mem_reg [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;

      assign push[gi]  = valid_in & ready_out & chan_sel[gi];
      assign pop[gi]   = valid[gi] & cons_ready[gi];
      assign valid[gi] = (count_reg != '0);
      assign full[gi]  = (count_reg == CNT_W'(DEPTH));
      // Storage is reset so the head reads as zero while reset is held.
      assign head[gi]  = mem_reg[rd_ptr_reg];

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push[gi]) begin
          mem_reg[wr_ptr_reg] <= d_in;
        end
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

`ifdef DEMUX_STATS_EN
      logic [15:0] cnt_reg;

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          cnt_reg <= '0;
        end else if (stats_clr_in) begin
          cnt_reg <= '0;
        end else if (pop[gi] && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign stat_cnt[gi] = cnt_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_demux_1to2_stream_buf.sv
// Directed bench for demux_1to2_stream_buf with a per-channel scoreboard queue.
// Define DEMUX_STATS_EN for both files to exercise the counter ports.
`timescale 1ns/1ps
module tb_demux_1to2_stream_buf;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [DATA_W-1:0] d_in;
  logic              sel_in;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] y0_data_out;
  logic              y0_valid_out;
  logic              y0_ready_in;
  logic [DATA_W-1:0] y1_data_out;
  logic              y1_valid_out;
  logic              y1_ready_in;
`ifdef DEMUX_STATS_EN
  logic              stats_clr_in;
  logic [15:0]       y0_cnt_out;
  logic [15:0]       y1_cnt_out;
`endif

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp0[$];
  logic [DATA_W-1:0] exp1[$];

  always #5 clk_in = ~clk_in;

  demux_1to2_stream_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(d_in), .sel_in(sel_in),
    .valid_in(valid_in), .ready_out(ready_out),
    .y0_data_out(y0_data_out), .y0_valid_out(y0_valid_out), .y0_ready_in(y0_ready_in),
    .y1_data_out(y1_data_out), .y1_valid_out(y1_valid_out), .y1_ready_in(y1_ready_in)
`ifdef DEMUX_STATS_EN
    , .stats_clr_in(stats_clr_in), .y0_cnt_out(y0_cnt_out), .y1_cnt_out(y1_cnt_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: score accepts/pops at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk_in);
    if (valid_in && ready_out) begin
      if (sel_in) exp0.push_back(d_in);
      else        exp1.push_back(d_in);
      $display("push sel=%0b data=%h", sel_in, d_in);
    end
    if (y0_valid_out && y0_ready_in) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $error("FAIL y0_extra observed=%h expected=none", y0_data_out);
      end else chk("y0_data", 32'(y0_data_out), 32'(exp0.pop_front()));
      $display("pop  ch0 data=%h", y0_data_out);
    end
    if (y1_valid_out && y1_ready_in) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $error("FAIL y1_extra observed=%h expected=none", y1_data_out);
      end else chk("y1_data", 32'(y1_data_out), 32'(exp1.pop_front()));
      $display("pop  ch1 data=%h", y1_data_out);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) cycle();
    chk("q0_drained", 32'(exp0.size()), 32'd0);
    chk("q1_drained", 32'(exp1.size()), 32'd0);
  endtask

  initial begin
    rst_n_in = 1'b0; d_in = '0; sel_in = 1'b1; valid_in = 1'b0;
    y0_ready_in = 1'b1; y1_ready_in = 1'b1;
`ifdef DEMUX_STATS_EN
    stats_clr_in = 1'b0;
`endif
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_v0", 32'(y0_valid_out), 32'd0);
    chk("rst_v1", 32'(y1_valid_out), 32'd0);
    chk("rst_d0", 32'(y0_data_out), 32'd0);
    chk("rst_d1", 32'(y1_data_out), 32'd0);
    rst_n_in = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ready_out), 32'd1);

    // Routing and one-cycle latency
    d_in = 8'hA5; sel_in = 1'b1; valid_in = 1'b1;
    cycle();
    chk("t1_v0_on", 32'(y0_valid_out), 32'd1);
    d_in = 8'h3C; sel_in = 1'b0;
    cycle();
    valid_in = 1'b0;
    chk("t1_v0_off", 32'(y0_valid_out), 32'd0);
    chk("t1_v1_on", 32'(y1_valid_out), 32'd1);
    cycle();
    chk("t1_v1_off", 32'(y1_valid_out), 32'd0);
    drain();

    // Fill ch0 with its consumer stalled
    y0_ready_in = 1'b0; sel_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d_in = 8'(i); valid_in = 1'b1;
      chk("t2_ready_fill", 32'(ready_out), 32'd1);
      cycle();
    end
    d_in = 8'h05;
    chk("t2_ready_full", 32'(ready_out), 32'd0);
    cycle();
    valid_in = 1'b0; sel_in = 1'b0;
    #1;
    chk("t2_ready_other", 32'(ready_out), 32'd1);

    // Pop from a full channel: no same-cycle ready pass-through
    sel_in = 1'b1; valid_in = 1'b1; d_in = 8'h05; y0_ready_in = 1'b1;
    #1;
    chk("t3_ready_popcyc", 32'(ready_out), 32'd0);
    cycle();
    chk("t3_ready_next", 32'(ready_out), 32'd1);
    cycle();
    valid_in = 1'b0;
    drain();

    // Back-to-back stream through ch1, wrapping the pointers
    sel_in = 1'b0; y1_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_in = 8'(8'h10 + i); valid_in = 1'b1;
      chk("t4_ready", 32'(ready_out), 32'd1);
      if (i > 0) chk("t4_v1", 32'(y1_valid_out), 32'd1);
      cycle();
    end
    valid_in = 1'b0;
    drain();

    // Reset in the middle of operation
    y0_ready_in = 1'b0; y1_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_in = 8'(8'h40 + i); sel_in = (i < 3); valid_in = 1'b1;
      cycle();
    end
    valid_in = 1'b0;
    chk("t5_pre_v0", 32'(y0_valid_out), 32'd1);
    chk("t5_pre_v1", 32'(y1_valid_out), 32'd1);
    #1 rst_n_in = 1'b0;
    #1;
    chk("t5_rst_v0", 32'(y0_valid_out), 32'd0);
    chk("t5_rst_v1", 32'(y1_valid_out), 32'd0);
    chk("t5_rst_ready", 32'(ready_out), 32'd0);
    #1 rst_n_in = 1'b1;
    exp0.delete(); exp1.delete();
    y0_ready_in = 1'b1; y1_ready_in = 1'b1; sel_in = 1'b1;
    #0.5;
    chk("t5_ready_sel1", 32'(ready_out), 32'd1);
    sel_in = 1'b0;
    #0.5;
    chk("t5_ready_sel0", 32'(ready_out), 32'd1);
    repeat (3) cycle();
    chk("t5_after_v0", 32'(y0_valid_out), 32'd0);
    chk("t5_after_v1", 32'(y1_valid_out), 32'd0);

`ifdef DEMUX_STATS_EN
    // Delivered-word counters
    sel_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = 8'(8'h70 + i); valid_in = 1'b1;
      cycle();
    end
    valid_in = 1'b0;
    drain();
    chk("t6_cnt3", 32'(y0_cnt_out), 32'd3);
    force dut.g_ch[0].cnt_reg = 16'hFFFF;
    #1;
    release dut.g_ch[0].cnt_reg;
    d_in = 8'h7A; valid_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    drain();
    chk("t6_sat", 32'(y0_cnt_out), 32'h0000FFFF);
    d_in = 8'h7B; valid_in = 1'b1;
    cycle();
    valid_in = 1'b0; stats_clr_in = 1'b1;
    chk("t6_pop_in_clr", 32'(y0_valid_out), 32'd1);
    cycle();
    stats_clr_in = 1'b0;
    chk("t6_clr", 32'(y0_cnt_out), 32'd0);
    chk("t6_cnt1_zero", 32'(y1_cnt_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
